// File: rtl/systolic_mmu_if.sv
// systolic_mmu_if -- job, operand-stream and result-stream signals of the
// systolic matrix-multiply unit.
//   master : drives start/acc_mode/k_len, the a_in/b_in beat stream (in_valid)
//            and out_ready; observes in_ready, out_valid, out_row, c_out, busy.
//   slave  : the systolic_mmu side (mirror image of master).
// a_in[i] feeds PE row i, b_in[j] feeds PE column j; c_out[j] is element j
// of the accumulator row selected by out_row. All elements are two's complement.
interface systolic_mmu_if #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int KW      = 8
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                           start;
    logic                           acc_mode;
    logic [KW-1:0]                  k_len;
    logic                           in_valid;
    logic                           in_ready;
    logic [ROWS-1:0][BITS_AB-1:0]   a_in;
    logic [COLS-1:0][BITS_AB-1:0]   b_in;
    logic                           out_valid;
    logic                           out_ready;
    logic [RW-1:0]                  out_row;
    logic [COLS-1:0][BITS_C-1:0]    c_out;
    logic                           busy;

    modport master (
        output start, acc_mode, k_len, in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_row, c_out, busy
    );

    modport slave (
        input  start, acc_mode, k_len, in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_row, c_out, busy
    );
endinterface

// File: rtl/systolic_mmu.sv
// systolic_mmu -- output-stationary ROWS x COLS systolic array computing
// C[i][j] (+)= sum_k A[i][k] * B[k][j].
//   clk, rst : single clock, synchronous active-high reset.
//   bus      : systolic_mmu_if slave port (job start, operand beats in,
//              result rows out, busy).
// Each accepted beat advances the array one step; A row i and B column j are
// skewed by i and j steps so operands of the same k meet in PE(i,j) at step
// t+i+j. FLUSH pushes ROWS+COLS-2 zero steps to finish the wavefront, then
// DRAIN streams accumulator rows out one per handshake.
module systolic_mmu #(
    parameter int BITS_AB  = 8,
    parameter int BITS_C   = 16,
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int KW       = 8,
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           rst,
    systolic_mmu_if.slave  bus
);
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FLUSH_N = ROWS + COLS - 2;
    localparam int FW      = $clog2(ROWS + COLS);
    // Sum width holds acc + full product without overflow before clamping.
    localparam int SW      = ((BITS_C > 2*BITS_AB) ? BITS_C : 2*BITS_AB) + 1;
    localparam logic signed [SW-1:0] SMAX = {{(SW-BITS_C+1){1'b0}}, {(BITS_C-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-BITS_C+1){1'b1}}, {(BITS_C-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t           state, state_nx;
    logic [KW-1:0]    k_len_q, beat_cnt;
    logic [FW-1:0]    flush_cnt;
    logic [RW-1:0]    row_q;
    logic             start_job, take, give, adv;
    logic             last_beat, last_flush, last_row;

    logic [BITS_AB-1:0] inj_a [ROWS];
    logic [BITS_AB-1:0] inj_b [COLS];
    logic [BITS_AB-1:0] a_tap [ROWS][COLS];
    logic [BITS_AB-1:0] b_tap [ROWS][COLS];
    logic [BITS_C-1:0]  acc   [ROWS][COLS];

    function automatic logic [BITS_C-1:0] mac(input logic [BITS_C-1:0]  c,
                                              input logic [BITS_AB-1:0] a,
                                              input logic [BITS_AB-1:0] b);
        logic signed [2*BITS_AB-1:0] p;
        logic signed [SW-1:0]        s;
        p = $signed(a) * $signed(b);
        s = SW'($signed(c)) + SW'(p);
        if (SATURATE != 0) begin
            if (s > SMAX) return SMAX[BITS_C-1:0];
            if (s < SMIN) return SMIN[BITS_C-1:0];
        end
        return s[BITS_C-1:0];
    endfunction

    assign start_job  = (state == IDLE) && bus.start;
    assign take       = (state == LOAD) && bus.in_valid;
    assign give       = (state == DRAIN) && bus.out_ready;
    assign adv        = take || (state == FLUSH);
    assign last_beat  = (beat_cnt == k_len_q - KW'(1));
    assign last_flush = (flush_cnt == FW'(FLUSH_N - 1));
    assign last_row   = (row_q == RW'(ROWS - 1));

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_nx; a missing
        // assignment in combinational logic infers a latch.
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start)
                       state_nx = (bus.k_len == '0) ? DRAIN : LOAD;
            LOAD:  if (bus.in_valid && last_beat)
                       state_nx = (FLUSH_N == 0) ? DRAIN : FLUSH;
            FLUSH: if (last_flush) state_nx = DRAIN;
            DRAIN: if (bus.out_ready && last_row) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state == LOAD);
        bus.out_valid = (state == DRAIN);
        bus.busy      = (state != IDLE);
    end

    // Job counters; k_len is captured so mid-job changes on the bus are inert.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_q     <= '0;
        end else begin
            if (start_job) begin
                k_len_q   <= bus.k_len;
                beat_cnt  <= '0;
                flush_cnt <= '0;
                row_q     <= '0;
            end
            if (take)            beat_cnt  <= beat_cnt + KW'(1);
            if (state == FLUSH)  flush_cnt <= flush_cnt + FW'(1);
            if (give)            row_q     <= last_row ? '0 : row_q + RW'(1);
        end
    end

    // Operands injected at the array edge: live data only in LOAD, zeros in
    // FLUSH. Outside those states the array does not advance at all.
    always_comb begin
        for (int i = 0; i < ROWS; i++) inj_a[i] = (state == LOAD) ? bus.a_in[i] : '0;
        for (int j = 0; j < COLS; j++) inj_b[j] = (state == LOAD) ? bus.b_in[j] : '0;
    end

    // Row i: one delay chain doing both the input skew (i steps) and the
    // left-to-right PE pipeline (j steps); PE(i,j) taps delay i+j.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        localparam int L = i + COLS - 1;
        if (L > 0) begin : g_chain
            logic [BITS_AB-1:0] d [1:L];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int n = 1; n <= L; n++) d[n] <= '0;
                end else if (adv) begin
                    d[1] <= inj_a[i];
                    for (int n = 2; n <= L; n++) d[n] <= d[n-1];
                end
            end
            for (genvar j = 0; j < COLS; j++) begin : g_tap
                if (i + j == 0) begin : g_direct
                    assign a_tap[i][j] = inj_a[i];
                end else begin : g_delayed
                    assign a_tap[i][j] = d[i+j];
                end
            end
        end else begin : g_nochain
            assign a_tap[i][0] = inj_a[i];
        end
    end

    // Column j: same structure, top-to-bottom.
    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int L = j + ROWS - 1;
        if (L > 0) begin : g_chain
            logic [BITS_AB-1:0] d [1:L];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int n = 1; n <= L; n++) d[n] <= '0;
                end else if (adv) begin
                    d[1] <= inj_b[j];
                    for (int n = 2; n <= L; n++) d[n] <= d[n-1];
                end
            end
            for (genvar i = 0; i < ROWS; i++) begin : g_tap
                if (i + j == 0) begin : g_direct
                    assign b_tap[i][j] = inj_b[j];
                end else begin : g_delayed
                    assign b_tap[i][j] = d[i+j];
                end
            end
        end else begin : g_nochain
            assign b_tap[0][j] = inj_b[j];
        end
    end

    // Accumulators: cleared by reset or by a clearing start, otherwise they
    // only change on an array step and persist across jobs.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator array is reset explicitly because reset must
        // clear results; array-shaped state is not zeroed by reset implicitly.
        if (rst || (start_job && !bus.acc_mode)) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= '0;
        end else if (adv) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    acc[i][j] <= mac(acc[i][j], a_tap[i][j], b_tap[i][j]);
        end
    end

    // Zero-latency row view; stable while out_ready is low since neither
    // row_q nor acc moves in DRAIN without a handshake.
    assign bus.out_row = row_q;
    always_comb begin
        for (int j = 0; j < COLS; j++) bus.c_out[j] = acc[row_q][j];
    end
endmodule

// File: tb/tb_systolic_mmu.sv
// tb_systolic_mmu -- directed self-checking bench for systolic_mmu (2x2,
// 8-bit operands, 16-bit results). A saturating and a wrapping instance see
// identical stimulus; expected values are hand-computed.
module tb_systolic_mmu;
    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int KW      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    systolic_mmu_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .ROWS(ROWS), .COLS(COLS), .KW(KW)) bus ();
    systolic_mmu_if #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .ROWS(ROWS), .COLS(COLS), .KW(KW)) bus_w ();

    assign bus_w.start     = bus.start;
    assign bus_w.acc_mode  = bus.acc_mode;
    assign bus_w.k_len     = bus.k_len;
    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.a_in      = bus.a_in;
    assign bus_w.b_in      = bus.b_in;
    assign bus_w.out_ready = bus.out_ready;

    systolic_mmu #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .ROWS(ROWS), .COLS(COLS),
                   .KW(KW), .SATURATE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_mmu #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .ROWS(ROWS), .COLS(COLS),
                   .KW(KW), .SATURATE(0)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks enter and leave on a falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  int'(bus.in_ready),  0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_busy"},      int'(bus.busy),      0);
        check({tag, "_out_row"},   int'(bus.out_row),   0);
        check({tag, "_c0"},        int'($signed(bus.c_out[0])), 0);
        check({tag, "_c1"},        int'($signed(bus.c_out[1])), 0);
    endtask

    task automatic start_job(input bit mode, input int k);
        bus.start    = 1'b1;
        bus.acc_mode = mode;
        bus.k_len    = KW'(k);
        cycle();
        bus.start    = 1'b0;
        // Scramble captured fields; the running job must not notice.
        bus.acc_mode = ~mode;
        bus.k_len    = 8'hff;
    endtask

    task automatic send_beat(input int a0, input int a1, input int b0, input int b1);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a_in[0]  = BITS_AB'(a0);
        bus.a_in[1]  = BITS_AB'(a1);
        bus.b_in[0]  = BITS_AB'(b0);
        bus.b_in[1]  = BITS_AB'(b1);
        while (!bus.in_ready && n < 20) begin
            cycle();
            n++;
        end
        check("beat_in_ready", int'(bus.in_ready), 1);
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int exp_cycles);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            cycle();
            n++;
        end
        check({tag, "_drain_latency"}, n, exp_cycles);
    endtask

    task automatic read_rows(input string tag, input int e00, input int e01,
                             input int e10, input int e11, input bit chk_w, input int w);
        int e [2][2];
        e[0][0] = e00; e[0][1] = e01; e[1][0] = e10; e[1][1] = e11;
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("%s_r%0d_valid", tag, r), int'(bus.out_valid), 1);
            check($sformatf("%s_r%0d_row", tag, r),   int'(bus.out_row),   r);
            check($sformatf("%s_r%0d_c0", tag, r), int'($signed(bus.c_out[0])), e[r][0]);
            check($sformatf("%s_r%0d_c1", tag, r), int'($signed(bus.c_out[1])), e[r][1]);
            if (chk_w) begin
                check($sformatf("%s_wrap_r%0d_c0", tag, r), int'($signed(bus_w.c_out[0])), w);
                check($sformatf("%s_wrap_r%0d_c1", tag, r), int'($signed(bus_w.c_out[1])), w);
            end
            bus.out_ready = 1'b1;
            cycle();
            bus.out_ready = 1'b0;
        end
        check({tag, "_done_busy"},      int'(bus.busy),      0);
        check({tag, "_done_out_valid"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.acc_mode  = 1'b0;
        bus.k_len     = '0;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("in_reset");
        rst = 1'b0;
        cycle();
        check_idle("after_reset");

        // Single beat, clearing job: C = a * b^T.
        start_job(1'b0, 1);
        check("j1_busy",     int'(bus.busy),     1);
        check("j1_in_ready", int'(bus.in_ready), 1);
        send_beat(2, 3, 4, 5);
        check("j1_flush_in_ready", int'(bus.in_ready), 0);
        check("j1_flush_busy",     int'(bus.busy),     1);
        wait_drain("j1", 2);
        read_rows("j1", 8, 10, 12, 15, 1'b0, 0);

        // Same job accumulating onto previous result, with a stalled drain.
        start_job(1'b1, 1);
        send_beat(2, 3, 4, 5);
        wait_drain("j2", 2);
        for (int s = 0; s < 5; s++) begin
            check($sformatf("hold%0d_row", s), int'(bus.out_row), 0);
            check($sformatf("hold%0d_c0", s),  int'($signed(bus.c_out[0])), 16);
            check($sformatf("hold%0d_c1", s),  int'($signed(bus.c_out[1])), 20);
            cycle();
        end
        read_rows("j2", 16, 20, 24, 30, 1'b0, 0);

        // Overflow: 2 * 16384 = 32768 clamps to 32767 or wraps to -32768.
        start_job(1'b0, 2);
        send_beat(-128, -128, -128, -128);
        send_beat(-128, -128, -128, -128);
        wait_drain("sat", 2);
        read_rows("sat", 32767, 32767, 32767, 32767, 1'b1, -32768);

        // Gapped beats plus a start pulse mid-LOAD that must be ignored.
        start_job(1'b0, 3);
        send_beat(1, 2, 1, 1);
        check("gap_in_ready", int'(bus.in_ready), 1);
        bus.start    = 1'b1;
        bus.k_len    = 8'd1;
        bus.acc_mode = 1'b1;
        cycle();
        bus.start = 1'b0;
        check("gap_still_load", int'(bus.in_ready), 1);
        send_beat(1, 2, 1, 1);
        repeat (3) cycle();
        send_beat(1, 2, 1, 1);
        wait_drain("gap", 2);
        read_rows("gap", 3, 3, 6, 6, 1'b0, 0);

        // Reset in the middle of LOAD, then an accumulating job from zero.
        start_job(1'b0, 3);
        send_beat(1, 1, 1, 1);
        rst = 1'b1;
        cycle();
        check_idle("mid_load_reset");
        rst = 1'b0;
        start_job(1'b1, 1);
        send_beat(1, 1, 1, 1);
        wait_drain("post_rst", 2);
        read_rows("post_rst", 1, 1, 1, 1, 1'b0, 0);

        // Zero-length accumulating job: straight to DRAIN, results retained.
        start_job(1'b1, 0);
        wait_drain("k0", 0);
        read_rows("k0", 1, 1, 1, 1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
